rc4_stream_gen: RTL and testbench

//  Parametrised RC4 keystream generator: successor of the fixed-key-size rc4 core.
//  - Takes the key as a byte stream over a valid/ready handshake.
//  - Runs the KSA, optionally discards the first DROP_N bytes (RC4-drop[n]).
//  - Emits keystream bytes on a valid/ready output port with full backpressure.
//  - Rekeys at runtime via restart; sits between the key source and the XOR/PRBS consumer.

---
 rtl/rc4_stream_gen.sv | 148 ++++++++++++++
 tb/tb_rc4_stream_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_gen.sv
// rc4_stream_gen: RC4 keystream generator with streamed key load, KSA,
// optional RC4-drop[n] discard, and a backpressured keystream output port.
module rc4_stream_gen #(
  parameter int KEY_SIZE = 8,
  parameter int DROP_N   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       key_valid,
  input  logic [7:0] key_byte,
  output logic       key_ready,
  output logic       busy,
  output logic       ks_valid,
  input  logic       ks_ready,
  output logic [7:0] ks_byte
);

  // Key index width; the key store is padded to a power of two so the
  // index never exceeds the array bounds.
  localparam int KW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
  localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_SIZE - 1);
  localparam logic [15:0]   DROP_LAST = (DROP_N > 0) ? 16'(DROP_N - 1) : 16'd0;

  typedef enum logic [2:0] {LOAD, INIT, KSA, DROP, GEN} state_t;

  state_t        state_q;
  logic [7:0]    s_q   [256];
  logic [7:0]    key_q [2**KW];
  logic [7:0]    i_q, j_q;
  logic [KW-1:0] cnt_q, kidx_q;
  logic [15:0]   drop_q;
  logic          ks_valid_q;
  logic [7:0]    ks_byte_q;

  // Step enables: rst and restart block every state change.
  logic run, key_we, init_en, ksa_en, prga_en, gen_fire;
  assign run      = !rst && !restart;
  assign key_we   = run && (state_q == LOAD) && key_valid;
  assign init_en  = run && (state_q == INIT);
  assign ksa_en   = run && (state_q == KSA);
  assign gen_fire = (state_q == GEN) && (!ks_valid_q || ks_ready);
  assign prga_en  = run && ((state_q == DROP) || gen_fire);

  // KSA iteration: j' = j + S[i] + key[i mod KEY_SIZE]; swap S[i], S[j'].
  logic [7:0] ksa_si, ksa_j, ksa_sj;
  assign ksa_si = s_q[i_q];
  assign ksa_j  = j_q + ksa_si + key_q[kidx_q];
  assign ksa_sj = s_q[ksa_j];

  // PRGA step; the output lookup uses post-swap values, so indices that hit
  // the swapped cells are forwarded from the swap operands.
  logic [7:0] pr_i, pr_j, pr_si, pr_sj, pr_t, pr_out;
  assign pr_i   = i_q + 8'd1;
  assign pr_si  = s_q[pr_i];
  assign pr_j   = j_q + pr_si;
  assign pr_sj  = s_q[pr_j];
  assign pr_t   = pr_si + pr_sj;
  assign pr_out = (pr_t == pr_i) ? pr_sj :
                  (pr_t == pr_j) ? pr_si : s_q[pr_t];

  // Key capture and S-box permutation; INIT rebuilds S so no reset is needed.
  always_ff @(posedge clk) begin
    if (key_we) key_q[cnt_q] <= key_byte;
    if (init_en) begin
      for (int k = 0; k < 256; k++) s_q[k] <= 8'(k);
    end else if (ksa_en) begin
      s_q[i_q]   <= ksa_sj;
      s_q[ksa_j] <= ksa_si;
    end else if (prga_en) begin
      s_q[pr_i] <= pr_sj;
      s_q[pr_j] <= pr_si;
    end
  end

  // Control FSM with registered keystream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      ks_valid_q <= 1'b0;
      ks_byte_q  <= 8'd0;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      cnt_q      <= '0;
      kidx_q     <= '0;
      drop_q     <= 16'd0;
    end else if (restart) begin
      state_q    <= LOAD;
      ks_valid_q <= 1'b0;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      cnt_q      <= '0;
      kidx_q     <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (key_valid) begin
            if (cnt_q == KEY_LAST) begin
              cnt_q   <= '0;
              state_q <= INIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        INIT: begin
          i_q     <= 8'd0;
          j_q     <= 8'd0;
          kidx_q  <= '0;
          state_q <= KSA;
        end
        KSA: begin
          kidx_q <= (kidx_q == KEY_LAST) ? '0 : kidx_q + 1'b1;
          if (i_q == 8'hFF) begin
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            drop_q  <= DROP_LAST;
            state_q <= (DROP_N > 0) ? DROP : GEN;
          end else begin
            i_q <= i_q + 8'd1;
            j_q <= ksa_j;
          end
        end
        DROP: begin
          i_q <= pr_i;
          j_q <= pr_j;
          if (drop_q == 16'd0) state_q <= GEN;
          else                 drop_q  <= drop_q - 16'd1;
        end
        GEN: begin
          if (gen_fire) begin
            i_q        <= pr_i;
            j_q        <= pr_j;
            ks_byte_q  <= pr_out;
            ks_valid_q <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign key_ready = (state_q == LOAD);
  assign busy      = (state_q == INIT) || (state_q == KSA) || (state_q == DROP);
  assign ks_valid  = ks_valid_q;
  assign ks_byte   = ks_byte_q;

endmodule

// File: tb/tb_rc4_stream_gen.sv
// Bench for rc4_stream_gen: five instances with different KEY_SIZE/DROP_N,
// table-driven keystream vectors plus restart, reset and random-backpressure sequences.
module tb_rc4_stream_gen;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             restart = 1'b0;
  logic             ks_ready = 1'b0;
  logic [7:0]       key_byte = 8'd0;
  logic [4:0]       key_valid = '0;
  logic [4:0]       key_ready, busy, ks_valid;
  logic [4:0][7:0]  ks_byte;

  always #5 clk = ~clk;

  rc4_stream_gen #(.KEY_SIZE(3), .DROP_N(0)) u0 (.clk(clk), .rst(rst), .restart(restart),
    .key_valid(key_valid[0]), .key_byte(key_byte), .key_ready(key_ready[0]), .busy(busy[0]),
    .ks_valid(ks_valid[0]), .ks_ready(ks_ready), .ks_byte(ks_byte[0]));
  rc4_stream_gen #(.KEY_SIZE(3), .DROP_N(2)) u1 (.clk(clk), .rst(rst), .restart(restart),
    .key_valid(key_valid[1]), .key_byte(key_byte), .key_ready(key_ready[1]), .busy(busy[1]),
    .ks_valid(ks_valid[1]), .ks_ready(ks_ready), .ks_byte(ks_byte[1]));
  rc4_stream_gen #(.KEY_SIZE(6), .DROP_N(0)) u2 (.clk(clk), .rst(rst), .restart(restart),
    .key_valid(key_valid[2]), .key_byte(key_byte), .key_ready(key_ready[2]), .busy(busy[2]),
    .ks_valid(ks_valid[2]), .ks_ready(ks_ready), .ks_byte(ks_byte[2]));
  rc4_stream_gen #(.KEY_SIZE(4), .DROP_N(0)) u3 (.clk(clk), .rst(rst), .restart(restart),
    .key_valid(key_valid[3]), .key_byte(key_byte), .key_ready(key_ready[3]), .busy(busy[3]),
    .ks_valid(ks_valid[3]), .ks_ready(ks_ready), .ks_byte(ks_byte[3]));
  rc4_stream_gen #(.KEY_SIZE(8), .DROP_N(0)) u4 (.clk(clk), .rst(rst), .restart(restart),
    .key_valid(key_valid[4]), .key_byte(key_byte), .key_ready(key_ready[4]), .busy(busy[4]),
    .ks_valid(ks_valid[4]), .ks_ready(ks_ready), .ks_byte(ks_byte[4]));

  int n_err = 0;
  int n_checks = 0;
  logic [7:0] exp_mem [2048];
  logic [7:0] ref_key [256];

  typedef struct packed {
    logic [2:0]      dut;
    logic [3:0]      klen;
    logic [7:0][7:0] key;   // key[0] is the first byte sent
    logic [1:0]      mode;  // 0: ks_ready held high, 1: ks_ready toggles
    logic [9:0]      lat;
    logic [3:0]      nexp;
    logic [9:0][7:0] exp;   // exp[0] is the first keystream byte
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Plain software RC4 producing nb keystream bytes into exp_mem.
  task automatic rc4_ref(input int klen, input int nb);
    int s [256];
    int i, j, t;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(ref_key[k % klen])) % 256;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < nb; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_mem[n] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  // Called at a sample point (1 time unit after an edge); returns at the same phase.
  task automatic load_key(input int d, input int n, input logic [7:0][7:0] kb);
    check($sformatf("key_ready_before_load_d%0d", d), int'(key_ready[d]), 1);
    for (int k = 0; k < n; k++) begin
      key_valid[d] = 1'b1;
      key_byte = kb[k];
      @(posedge clk); #1;
    end
    key_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (!ks_valid[d] && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Consume keystream bytes and compare with exp_mem; mode 0 ready high,
  // 1 ready toggling, 2 ready random. Stalled bytes must hold.
  task automatic collect(input int d, input int n, input int mode, input int maxcyc,
                         input string tag, output int got);
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pb = 8'd0;
    got = 0;
    while (got < n && cyc < maxcyc) begin
      if (pv && !pr) begin
        check({tag, "_stall_valid"}, int'(ks_valid[d]), 1);
        check({tag, "_stall_hold"}, int'(ks_byte[d]), int'(pb));
      end
      case (mode)
        0:       ks_ready = 1'b1;
        1:       ks_ready = (cyc % 2 == 0);
        default: ks_ready = 1'($urandom_range(0, 1));
      endcase
      if (ks_valid[d] && ks_ready) begin
        check($sformatf("%s_byte%0d", tag, got), int'(ks_byte[d]), int'(exp_mem[got]));
        $display("%s: byte %0d = %02h (expected %02h)", tag, got, ks_byte[d], exp_mem[got]);
        got++;
      end
      pv = ks_valid[d]; pr = ks_ready; pb = ks_byte[d];
      if (got < n) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    ks_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, got;
    logic [7:0][7:0] key_key;
    logic [7:0][7:0] key_wiki;
    key_key  = 64'h0000_0000_0079_654B;
    key_wiki = 64'h0000_0000_696B_6957;

    vecs[0] = '{dut: 3'd0, klen: 4'd3, key: 64'h0000_0000_0079_654B, mode: 2'd0,
                lat: 10'd258, nexp: 4'd10, exp: 80'h19A7_72CA_34B7_8177_9FEB};
    vecs[1] = '{dut: 3'd2, klen: 4'd6, key: 64'h0000_7465_7263_6553, mode: 2'd1,
                lat: 10'd258, nexp: 4'd8,  exp: 80'h0000_597B_A83C_056B_D404};
    vecs[2] = '{dut: 3'd1, klen: 4'd3, key: 64'h0000_0000_0079_654B, mode: 2'd0,
                lat: 10'd260, nexp: 4'd4,  exp: 80'h0000_0000_0000_34B7_8177};

    // Reset state of every instance.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      check($sformatf("reset_key_ready_d%0d", d), int'(key_ready[d]), 1);
      check($sformatf("reset_ks_valid_d%0d", d), int'(ks_valid[d]), 0);
      check($sformatf("reset_ks_byte_d%0d", d), int'(ks_byte[d]), 0);
      check($sformatf("reset_busy_d%0d", d), int'(busy[d]), 0);
    end
    rst = 1'b0;

    // Table-driven keystream vectors.
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 10; k++) exp_mem[k] = vecs[v].exp[k];
      load_key(int'(vecs[v].dut), int'(vecs[v].klen), vecs[v].key);
      check($sformatf("vec%0d_busy", v), int'(busy[vecs[v].dut]), 1);
      wait_valid(int'(vecs[v].dut), lat);
      check($sformatf("vec%0d_latency", v), lat, int'(vecs[v].lat));
      collect(int'(vecs[v].dut), int'(vecs[v].nexp), int'(vecs[v].mode), 200,
              $sformatf("vec%0d", v), got);
      check($sformatf("vec%0d_count", v), got, int'(vecs[v].nexp));
    end

    // Restart during LOAD (partial key) and mid-KSA, with a key byte offered in the restart cycle.
    load_key(3, 2, key_wiki);
    restart = 1'b1; key_valid[3] = 1'b1; key_byte = 8'h55;
    @(posedge clk); #1;
    restart = 1'b0; key_valid[3] = 1'b0;
    check("rs_load_key_ready", int'(key_ready[3]), 1);
    load_key(3, 4, key_wiki);
    repeat (100) @(posedge clk);
    #1;
    check("rs_ksa_busy", int'(busy[3]), 1);
    check("rs_ksa_key_ready", int'(key_ready[3]), 0);
    restart = 1'b1; key_valid[3] = 1'b1; key_byte = 8'h57;
    @(posedge clk); #1;
    restart = 1'b0; key_valid[3] = 1'b0;
    check("rs_after_key_ready", int'(key_ready[3]), 1);
    check("rs_after_busy", int'(busy[3]), 0);
    check("rs_after_ks_valid", int'(ks_valid[3]), 0);
    load_key(3, 4, key_wiki);
    wait_valid(3, lat);
    check("rs_latency", lat, 258);
    exp_mem[0] = 8'h60; exp_mem[1] = 8'h44; exp_mem[2] = 8'hDB;
    exp_mem[3] = 8'h6D; exp_mem[4] = 8'h41; exp_mem[5] = 8'hB7;
    collect(3, 6, 0, 100, "wiki", got);
    check("wiki_count", got, 6);

    // Synchronous reset during GEN, then reload.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_mem[0] = 8'hEB; exp_mem[1] = 8'h9F; exp_mem[2] = 8'h77;
    exp_mem[3] = 8'h81; exp_mem[4] = 8'hB7;
    load_key(0, 3, key_key);
    wait_valid(0, lat);
    check("rst_pre_latency", lat, 258);
    collect(0, 5, 0, 100, "rst_pre", got);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_gen_ks_valid", int'(ks_valid[0]), 0);
    check("rst_gen_ks_byte", int'(ks_byte[0]), 0);
    check("rst_gen_key_ready", int'(key_ready[0]), 1);
    check("rst_gen_busy", int'(busy[0]), 0);
    rst = 1'b0;
    load_key(0, 3, key_key);
    wait_valid(0, lat);
    check("rst_post_latency", lat, 258);
    collect(0, 3, 0, 100, "rst_post", got);
    check("rst_post_count", got, 3);

    // Random backpressure against the software reference, key 42 x8.
    for (int k = 0; k < 8; k++) ref_key[k] = 8'h42;
    rc4_ref(8, 2048);
    load_key(4, 8, 64'h4242_4242_4242_4242);
    wait_valid(4, lat);
    check("rand_latency", lat, 258);
    collect(4, 2048, 2, 2000, "rand", got);
    check("rand_progress", int'(got >= 400), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
